mem_port_arbiter: RTL and testbench

Shares the single-port, word-aligned, 64 KB byte memory between the instruction-fetch requester (read-only) and the load/store requester (read/write) of the multicycle core. Each access is a req/ack transaction: the arbiter latches the winning request, drives the memory's address, write-data and write-enable for a programmable number of cycles, then returns one ack pulse and the captured read word. Conflicts are resolved by round-robin. The arbiter is the only block that drives the memory ports.

---
 rtl/mem_port_arbiter_if.sv | 41 ++++
 rtl/mem_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The master modport is the environment (requesters plus memory); the slave modport is the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned DATA_W = 32;

    // instruction-fetch requester
    logic              i_req;
    logic [ADDR_W-1:0] i_adr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    // load/store requester
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_adr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    // single-port memory
    logic [ADDR_W-1:0] mem_adr;
    logic [DATA_W-1:0] to_be_written_data;
    logic              MemWrite;
    logic [DATA_W-1:0] read_data;

    logic              busy;

    modport master (
        output i_req, i_adr, d_req, d_we, d_adr, d_wdata, read_data,
        input  i_ack, i_rdata, d_ack, d_rdata,
        input  mem_adr, to_be_written_data, MemWrite, busy
    );

    modport slave (
        input  i_req, i_adr, d_req, d_we, d_adr, d_wdata, read_data,
        output i_ack, i_rdata, d_ack, d_rdata,
        output mem_adr, to_be_written_data, MemWrite, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one word-aligned memory port between the
// fetch requester (read-only) and the load/store requester.
// Every access is held on the memory for LATENCY cycles, then acked for one cycle.
module mem_port_arbiter #(
    parameter int unsigned LATENCY = 1,
    parameter int unsigned ADDR_W  = 32
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DATA_W = 32;
    localparam logic [ADDR_W-1:0] WORD_MASK = ~(ADDR_W'(3));
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    state_t            state_q,     state_d;
    logic [CNT_W-1:0]  cnt_q,       cnt_d;
    owner_t            owner_q,     owner_d;
    owner_t            rr_last_q,   rr_last_d;
    logic [ADDR_W-1:0] adr_q,       adr_d;
    logic              we_q,        we_d;
    logic [DATA_W-1:0] wdata_q,     wdata_d;
    logic [ADDR_W-1:0] mem_adr_q,   mem_adr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q,    mem_we_d;
    logic              i_ack_q,     i_ack_d;
    logic              d_ack_q,     d_ack_d;
    logic [DATA_W-1:0] i_rdata_q,   i_rdata_d;
    logic [DATA_W-1:0] d_rdata_q,   d_rdata_d;
    logic              busy_q,      busy_d;
    owner_t            grant;

    // State and registered outputs; reset abandons any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= OWN_I;
            rr_last_q   <= OWN_I;
            adr_q       <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            adr_q       <= adr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            busy_q      <= busy_d;
        end
    end

    // Next state plus next value of every output register, as seen in the coming cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        adr_d       = adr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_adr_d   = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        busy_d      = 1'b0;
        grant       = OWN_I;

        case (state_q)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // On a conflict the requester not served last time wins.
                    if (bus.i_req && bus.d_req) begin
                        grant = (rr_last_q == OWN_I) ? OWN_D : OWN_I;
                    end else begin
                        grant = bus.d_req ? OWN_D : OWN_I;
                    end
                    owner_d     = grant;
                    adr_d       = (grant == OWN_D) ? bus.d_adr : bus.i_adr;
                    we_d        = (grant == OWN_D) && bus.d_we;
                    wdata_d     = (grant == OWN_D) ? bus.d_wdata : '0;
                    cnt_d       = CNT_LOAD;
                    state_d     = ACCESS;
                    busy_d      = 1'b1;
                    mem_adr_d   = adr_d & WORD_MASK;
                    mem_wdata_d = wdata_d;
                    // a single-cycle access writes in its first (and last) cycle
                    mem_we_d    = we_d && (cnt_d == '0);
                end
            end

            ACCESS: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    // Last access cycle: capture the read word and ack in the next cycle.
                    state_d = RESP;
                    if (owner_q == OWN_D) begin
                        d_ack_d = 1'b1;
                        if (!we_q) begin
                            d_rdata_d = bus.read_data;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.read_data;
                    end
                end else begin
                    cnt_d       = cnt_q - CNT_W'(1);
                    mem_adr_d   = adr_q & WORD_MASK;
                    mem_wdata_d = wdata_q;
                    // exactly one write edge per store, at the end of the last cycle
                    mem_we_d    = we_q && (cnt_d == '0);
                end
            end

            RESP: begin
                rr_last_d = owner_q;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.mem_adr            = mem_adr_q;
    assign bus.to_be_written_data = mem_wdata_q;
    assign bus.MemWrite           = mem_we_q;
    assign bus.i_ack              = i_ack_q;
    assign bus.d_ack              = d_ack_q;
    assign bus.i_rdata            = i_rdata_q;
    assign bus.d_rdata            = d_rdata_q;
    assign bus.busy               = busy_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances (LATENCY 1, 4, 2), each with
// its own word memory; expected acks are queued when a request is driven.
module tb_mem_port_arbiter;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32)) b0 ();
    mem_port_arbiter_if #(.ADDR_W(32)) b1 ();
    mem_port_arbiter_if #(.ADDR_W(32)) b2 ();

    mem_port_arbiter #(.LATENCY(1), .ADDR_W(32)) u0 (.clk(clk), .rst(rst), .bus(b0));
    mem_port_arbiter #(.LATENCY(4), .ADDR_W(32)) u1 (.clk(clk), .rst(rst), .bus(b1));
    mem_port_arbiter #(.LATENCY(2), .ADDR_W(32)) u2 (.clk(clk), .rst(rst), .bus(b2));

    // requester drive per instance
    logic        i_req_s [3];
    logic        d_req_s [3];
    logic        d_we_s  [3];
    logic [31:0] i_adr_s [3];
    logic [31:0] d_adr_s [3];
    logic [31:0] d_wdata_s [3];

    // observed outputs per instance
    logic        i_ack_o [3];
    logic        d_ack_o [3];
    logic        mw_o    [3];
    logic        busy_o  [3];
    logic [31:0] i_rd_o  [3];
    logic [31:0] d_rd_o  [3];
    logic [31:0] madr_o  [3];
    logic [31:0] mwd_o   [3];

    logic [31:0] mem [3][16384];
    int          mw_cnt [3];
    int          cyc;

    assign b0.i_req = i_req_s[0]; assign b0.i_adr = i_adr_s[0];
    assign b0.d_req = d_req_s[0]; assign b0.d_we  = d_we_s[0];
    assign b0.d_adr = d_adr_s[0]; assign b0.d_wdata = d_wdata_s[0];
    assign b0.read_data = mem[0][madr_o[0][15:2]];
    assign b1.i_req = i_req_s[1]; assign b1.i_adr = i_adr_s[1];
    assign b1.d_req = d_req_s[1]; assign b1.d_we  = d_we_s[1];
    assign b1.d_adr = d_adr_s[1]; assign b1.d_wdata = d_wdata_s[1];
    assign b1.read_data = mem[1][madr_o[1][15:2]];
    assign b2.i_req = i_req_s[2]; assign b2.i_adr = i_adr_s[2];
    assign b2.d_req = d_req_s[2]; assign b2.d_we  = d_we_s[2];
    assign b2.d_adr = d_adr_s[2]; assign b2.d_wdata = d_wdata_s[2];
    assign b2.read_data = mem[2][madr_o[2][15:2]];

    assign i_ack_o[0] = b0.i_ack; assign d_ack_o[0] = b0.d_ack; assign mw_o[0] = b0.MemWrite;
    assign busy_o[0]  = b0.busy;  assign i_rd_o[0]  = b0.i_rdata; assign d_rd_o[0] = b0.d_rdata;
    assign madr_o[0]  = b0.mem_adr; assign mwd_o[0] = b0.to_be_written_data;
    assign i_ack_o[1] = b1.i_ack; assign d_ack_o[1] = b1.d_ack; assign mw_o[1] = b1.MemWrite;
    assign busy_o[1]  = b1.busy;  assign i_rd_o[1]  = b1.i_rdata; assign d_rd_o[1] = b1.d_rdata;
    assign madr_o[1]  = b1.mem_adr; assign mwd_o[1] = b1.to_be_written_data;
    assign i_ack_o[2] = b2.i_ack; assign d_ack_o[2] = b2.d_ack; assign mw_o[2] = b2.MemWrite;
    assign busy_o[2]  = b2.busy;  assign i_rd_o[2]  = b2.i_rdata; assign d_rd_o[2] = b2.d_rdata;
    assign madr_o[2]  = b2.mem_adr; assign mwd_o[2] = b2.to_be_written_data;

    // Memory model: preload, write on each MemWrite edge, count write edges.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc == 0) begin
            mem[0][0]   <= 32'h1111_1111;
            mem[1][16]  <= 32'h0050_0093;
            mem[1][128] <= 32'hCAFE_F00D;
            mem[2][0]   <= 32'hA5A5_A5A5;
            mem[2][192] <= 32'h5A5A_0300;
        end
        for (int k = 0; k < 3; k++) begin
            if (mw_o[k] === 1'b1) begin
                mem[k][madr_o[k][15:2]] <= mwd_o[k];
                mw_cnt[k] <= mw_cnt[k] + 1;
            end
        end
    end

    typedef struct {
        string       tag;
        bit          port;   // 1 = data, 0 = fetch
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for an ack on instance k and check it against the queue head.
    task automatic wait_ack(input int k);
        exp_t e;
        int   n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(i_ack_o[k] === 1'b1 || d_ack_o[k] === 1'b1) && n < 40);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({e.tag, "_port"}, 64'({d_ack_o[k], i_ack_o[k]}), e.port ? 64'd2 : 64'd1);
            chk({e.tag, "_data"}, 64'(e.port ? d_rd_o[k] : i_rd_o[k]), 64'(e.data));
            chk({e.tag, "_cycle"}, 64'(cyc), 64'(e.cyc));
        end else begin
            chk("unexpected_ack", 64'({d_ack_o[k], i_ack_o[k]}), 64'd0);
        end
    endtask

    initial begin
        int c;
        int n_ack;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_req_s[k] = 1'b0; d_req_s[k] = 1'b0; d_we_s[k] = 1'b0;
            i_adr_s[k] = '0;   d_adr_s[k] = '0;   d_wdata_s[k] = '0;
        end
        repeat (2) @(negedge clk);

        // reset state on every instance
        for (int k = 0; k < 3; k++) begin
            chk("rst_ctl",  64'({i_ack_o[k], d_ack_o[k], mw_o[k], busy_o[k]}), 64'd0);
            chk("rst_rd",   {i_rd_o[k], d_rd_o[k]}, 64'd0);
            chk("rst_bus",  {madr_o[k], mwd_o[k]}, 64'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_busy", 64'(busy_o[0]), 64'd0);
        chk("idle_mw_cnt", 64'(mw_cnt[0]), 64'd0);

        // LATENCY=1: store 0xDEADBEEF to 0x100
        c = cyc;
        d_req_s[0] = 1'b1; d_we_s[0] = 1'b1; d_adr_s[0] = 32'h100; d_wdata_s[0] = 32'hDEAD_BEEF;
        exp_q.push_back('{"st", 1'b1, 32'h0, c + 2});
        @(negedge clk);
        chk("st_mw", 64'(mw_o[0]), 64'd1);
        chk("st_adr", 64'(madr_o[0]), 64'h100);
        chk("st_wdata", 64'(mwd_o[0]), 64'hDEAD_BEEF);
        wait_ack(0);
        d_req_s[0] = 1'b0; d_we_s[0] = 1'b0;
        chk("st_mw_once", 64'(mw_cnt[0]), 64'd1);

        // LATENCY=1: misaligned load from 0x102 reads the word at 0x100
        @(negedge clk);
        c = cyc;
        d_req_s[0] = 1'b1; d_adr_s[0] = 32'h102;
        exp_q.push_back('{"ld", 1'b1, 32'hDEAD_BEEF, c + 2});
        @(negedge clk);
        chk("ld_adr", 64'(madr_o[0]), 64'h100);
        chk("ld_mw", 64'(mw_o[0]), 64'd0);
        wait_ack(0);
        d_req_s[0] = 1'b0;
        repeat (3) @(negedge clk);
        chk("ld_hold", 64'(d_rd_o[0]), 64'hDEAD_BEEF);
        chk("ld_mw_cnt", 64'(mw_cnt[0]), 64'd1);

        // LATENCY=1: conflict from reset, then 6 continuous alternating grants
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        c = cyc;
        i_req_s[0] = 1'b1; i_adr_s[0] = 32'h0;
        d_req_s[0] = 1'b1; d_we_s[0] = 1'b0; d_adr_s[0] = 32'h100;
        exp_q.push_back('{"rr0_d", 1'b1, 32'hDEAD_BEEF, c + 2});
        exp_q.push_back('{"rr1_i", 1'b0, 32'h1111_1111, c + 5});
        exp_q.push_back('{"rr2_d", 1'b1, 32'hDEAD_BEEF, c + 8});
        exp_q.push_back('{"rr3_i", 1'b0, 32'h1111_1111, c + 11});
        exp_q.push_back('{"rr4_d", 1'b1, 32'hDEAD_BEEF, c + 14});
        exp_q.push_back('{"rr5_i", 1'b0, 32'h1111_1111, c + 17});
        for (int j = 0; j < 6; j++) begin
            wait_ack(0);
            if (j == 4) d_req_s[0] = 1'b0;
            if (j == 5) i_req_s[0] = 1'b0;
        end
        @(negedge clk);

        // LATENCY=4: fetch of 0x40
        c = cyc;
        i_req_s[1] = 1'b1; i_adr_s[1] = 32'h40;
        exp_q.push_back('{"f4", 1'b0, 32'h0050_0093, c + 5});
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            chk("f4_adr", 64'(madr_o[1]), 64'h40);
            chk("f4_busy", 64'(busy_o[1]), 64'd1);
        end
        wait_ack(1);
        chk("f4_busy_resp", 64'(busy_o[1]), 64'd1);
        i_req_s[1] = 1'b0;
        @(negedge clk);
        chk("f4_busy_idle", 64'(busy_o[1]), 64'd0);

        // LATENCY=4: reset in the 2nd access cycle of a store suppresses it
        c = cyc;
        d_req_s[1] = 1'b1; d_we_s[1] = 1'b1; d_adr_s[1] = 32'h200; d_wdata_s[1] = 32'h1234_5678;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        d_req_s[1] = 1'b0; d_we_s[1] = 1'b0;
        #1;
        chk("rs_mw", 64'(mw_o[1]), 64'd0);
        chk("rs_busy", 64'(busy_o[1]), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        n_ack = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_ack_o[1] === 1'b1) n_ack++;
        end
        chk("rs_no_ack", 64'(n_ack), 64'd0);
        chk("rs_mw_cnt", 64'(mw_cnt[1]), 64'd0);
        c = cyc;
        d_req_s[1] = 1'b1; d_adr_s[1] = 32'h200;
        exp_q.push_back('{"rs_ld", 1'b1, 32'hCAFE_F00D, c + 5});
        wait_ack(1);
        d_req_s[1] = 1'b0;
        @(negedge clk);

        // LATENCY=2: data request arrives while a fetch is in flight
        c = cyc;
        i_req_s[2] = 1'b1; i_adr_s[2] = 32'h0;
        exp_q.push_back('{"wb_f", 1'b0, 32'hA5A5_A5A5, c + 3});
        @(negedge clk);
        d_req_s[2] = 1'b1; d_we_s[2] = 1'b0; d_adr_s[2] = 32'h300;
        exp_q.push_back('{"wb_d", 1'b1, 32'h5A5A_0300, c + 7});
        wait_ack(2);
        i_req_s[2] = 1'b0;
        @(negedge clk);
        chk("wb_idle_gap", 64'(busy_o[2]), 64'd0);
        wait_ack(2);
        d_req_s[2] = 1'b0;
        repeat (2) @(negedge clk);

        chk("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
